// File: rtl/jkff_bank.sv
// jkff_bank: a bank of WIDTH independent configurable flip-flops that share one clock.
// All channels use the same function, selected by mode: JK, D, T or SR.
// A sticky sr_err flag records any illegal SR input (S=R=1).
// Optional feature: define JKFF_BANK_TOGGLE_CNT_EN to add a 16-bit saturating
// counter, toggle_cnt, that counts the edges at which q changed.

module jkff_bank #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic             err_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
`ifdef JKFF_BANK_TOGGLE_CNT_EN
   output logic [15:0]      toggle_cnt,
`endif
   output logic             sr_err
);

   typedef enum logic [1:0] {
      MODE_JK = 2'b00,
      MODE_D  = 2'b01,
      MODE_T  = 2'b10,
      MODE_SR = 2'b11
   } mode_e;

   mode_e            mode_sel;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] illegal_vec;
   logic             illegal_any;
   logic             sr_err_q;
   logic             sr_err_d;

   assign mode_sel = mode_e'(mode);

   // Next state of each channel. Every bit is computed on its own, so an illegal SR
   // bit only holds itself and has no effect on the other channels.
   always_comb begin
      q_d         = q_q;
      illegal_vec = '0;
      if (en) begin
         for (int i = 0; i < WIDTH; i++) begin
            case (mode_sel)
               MODE_JK: begin
                  case ({j[i], k[i]})
                     2'b01:   q_d[i] = 1'b0;
                     2'b10:   q_d[i] = 1'b1;
                     2'b11:   q_d[i] = ~q_q[i];
                     default: q_d[i] = q_q[i];
                  endcase
               end
               MODE_D: begin
                  q_d[i] = j[i];
               end
               MODE_T: begin
                  q_d[i] = j[i] ? ~q_q[i] : q_q[i];
               end
               default: begin
                  case ({j[i], k[i]})
                     2'b01:   q_d[i] = 1'b0;
                     2'b10:   q_d[i] = 1'b1;
                     2'b11: begin
                        q_d[i]         = q_q[i];
                        illegal_vec[i] = 1'b1;
                     end
                     default: q_d[i] = q_q[i];
                  endcase
               end
            endcase
         end
      end
   end

   // Sticky error flag. A new illegal SR condition takes priority over err_clr.
   always_comb begin
      illegal_any = |illegal_vec;
      sr_err_d    = sr_err_q;
      if (illegal_any) begin
         sr_err_d = 1'b1;
      end else if (err_clr) begin
         sr_err_d = 1'b0;
      end
   end

   // Channel state and error flag registers. Reset is asynchronous and loads RESET_VAL.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q_q      <= RESET_VAL;
         sr_err_q <= 1'b0;
      end else begin
         q_q      <= q_d;
         sr_err_q <= sr_err_d;
      end
   end

`ifdef JKFF_BANK_TOGGLE_CNT_EN
   logic [15:0] toggle_cnt_q;
   logic [15:0] toggle_cnt_d;

   // Count the edges at which any bit of q changes. The counter saturates, and a
   // clear takes priority over an increment.
   always_comb begin
      toggle_cnt_d = toggle_cnt_q;
      if (err_clr) begin
         toggle_cnt_d = 16'h0000;
      end else if ((q_d != q_q) && (toggle_cnt_q != 16'hFFFF)) begin
         toggle_cnt_d = toggle_cnt_q + 16'd1;
      end
   end

   // Toggle counter register. It is cleared together with the channel state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         toggle_cnt_q <= 16'h0000;
      end else begin
         toggle_cnt_q <= toggle_cnt_d;
      end
   end

   assign toggle_cnt = toggle_cnt_q;
`endif

   assign q      = q_q;
   assign qbar   = ~q_q;
   assign sr_err = sr_err_q;

endmodule

// File: tb/tb_jkff_bank.sv
// Testbench for jkff_bank with WIDTH=4 and RESET_VAL=4'b0101.
// It runs directed scenarios and a randomized run. Each result is compared
// against a behavioural model that applies the flip-flop characteristic equations.

module tb_jkff_bank;

   localparam int       W    = 4;
   localparam logic [3:0] RV = 4'b0101;

   logic         clock = 1'b0;
   logic         reset;
   logic         en;
   logic [1:0]   mode;
   logic [W-1:0] j;
   logic [W-1:0] k;
   logic         err_clr;
   logic [W-1:0] q;
   logic [W-1:0] qbar;
   logic         sr_err;
`ifdef JKFF_BANK_TOGGLE_CNT_EN
   logic [15:0]  toggle_cnt;
   int           model_cnt;
`endif

   logic [W-1:0] model_q;
   logic         model_err;
   int           pass_cnt  = 0;
   int           check_cnt = 0;

   jkff_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
      .clock      (clock),
      .reset      (reset),
      .en         (en),
      .mode       (mode),
      .j          (j),
      .k          (k),
      .err_clr    (err_clr),
      .q          (q),
      .qbar       (qbar),
`ifdef JKFF_BANK_TOGGLE_CNT_EN
      .toggle_cnt (toggle_cnt),
`endif
      .sr_err     (sr_err)
   );

   always #5 clock = ~clock;

   // Characteristic equations: JK q+ = J~q | ~Kq; D q+ = D; T q+ = q^T;
   // SR: when S and R differ, q+ = S, otherwise the bit holds.
   function automatic logic [W-1:0] model_next(input logic e, input logic [1:0] m,
                                               input logic [W-1:0] jv, input logic [W-1:0] kv,
                                               input logic [W-1:0] qv);
      if (!e) return qv;
      case (m)
         2'd0:    return (jv & ~qv) | (~kv & qv);
         2'd1:    return jv;
         2'd2:    return qv ^ jv;
         default: return ((jv ^ kv) & jv) | (~(jv ^ kv) & qv);
      endcase
   endfunction

   task automatic model_reset();
      model_q   = RV;
      model_err = 1'b0;
`ifdef JKFF_BANK_TOGGLE_CNT_EN
      model_cnt = 0;
`endif
   endtask

   task automatic drive(input logic e, input logic [1:0] m, input logic [W-1:0] jv,
                        input logic [W-1:0] kv, input logic c);
      en      = e;
      mode    = m;
      j       = jv;
      k       = kv;
      err_clr = c;
   endtask

   // Step the model using the current inputs, then let one clock edge pass and settle.
   task automatic tick();
      logic [W-1:0] nq;
      nq = model_next(en, mode, j, k, model_q);
      if (en && mode == 2'd3 && ((j & k) != '0)) model_err = 1'b1;
      else if (err_clr)                          model_err = 1'b0;
`ifdef JKFF_BANK_TOGGLE_CNT_EN
      if (err_clr)                                 model_cnt = 0;
      else if (nq != model_q && model_cnt < 65535) model_cnt = model_cnt + 1;
`endif
      model_q = nq;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 2'd1, 4'b1111, 4'b0000, 1'b0);
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_cnt++;
      if (q !== RV) $display("[TB] FAIL reset_q got %b want %b", q, RV);
      else pass_cnt++;
      check_cnt++;
      if (qbar !== ~RV) $display("[TB] FAIL reset_qbar got %b want %b", qbar, ~RV);
      else pass_cnt++;
      check_cnt++;
      if (sr_err !== 1'b0) $display("[TB] FAIL reset_sr_err got %b want 0", sr_err);
      else pass_cnt++;
      reset = 1'b0;
      #2;
   endtask

   task automatic test_async_reset();
      drive(1'b1, 2'd3, 4'b0001, 4'b0001, 1'b0);
      tick();
      drive(1'b1, 2'd1, 4'b1111, 4'b0000, 1'b0);
      tick();
      check_cnt++;
      if (q !== 4'b1111 || sr_err !== 1'b1)
         $display("[TB] FAIL async_pre got q=%b err=%b want q=1111 err=1", q, sr_err);
      else pass_cnt++;
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_cnt++;
      if (q !== RV) $display("[TB] FAIL async_q got %b want %b", q, RV);
      else pass_cnt++;
      check_cnt++;
      if (qbar !== ~RV) $display("[TB] FAIL async_qbar got %b want %b", qbar, ~RV);
      else pass_cnt++;
      check_cnt++;
      if (sr_err !== 1'b0) $display("[TB] FAIL async_sr_err got %b want 0", sr_err);
      else pass_cnt++;
      @(posedge clock);
      #1;
      check_cnt++;
      if (q !== RV) $display("[TB] FAIL reset_hold_q got %b want %b", q, RV);
      else pass_cnt++;
      reset = 1'b0;
   endtask

   task automatic test_jk();
      drive(1'b1, 2'd0, 4'b1100, 4'b1010, 1'b0);
      tick();
      check_cnt++;
      if (q !== model_q) $display("[TB] FAIL jk_q got %b want %b", q, model_q);
      else pass_cnt++;
      check_cnt++;
      if (q !== 4'b1101) $display("[TB] FAIL jk_const got %b want 1101", q);
      else pass_cnt++;
   endtask

   task automatic test_t_mode();
      logic [W-1:0] exp_seq [3];
      exp_seq[0] = 4'b0001;
      exp_seq[1] = 4'b0000;
      exp_seq[2] = 4'b0001;
      drive(1'b1, 2'd1, 4'b0000, 4'b0000, 1'b0);
      tick();
      drive(1'b1, 2'd2, 4'b0001, 4'b1111, 1'b0);
      for (int n = 0; n < 3; n++) begin
         tick();
         check_cnt++;
         if (q !== exp_seq[n] || q !== model_q)
            $display("[TB] FAIL t_seq%0d got %b want %b", n, q, exp_seq[n]);
         else pass_cnt++;
      end
      drive(1'b0, 2'd2, 4'b0001, 4'b0000, 1'b0);
      for (int n = 0; n < 2; n++) begin
         tick();
         check_cnt++;
         if (q !== 4'b0001) $display("[TB] FAIL t_hold%0d got %b want 0001", n, q);
         else pass_cnt++;
      end
   endtask

   task automatic test_sr();
      drive(1'b1, 2'd1, 4'b1000, 4'b0000, 1'b1);
      tick();
      drive(1'b1, 2'd3, 4'b0011, 4'b0110, 1'b0);
      tick();
      check_cnt++;
      if (q !== 4'b1001 || q !== model_q) $display("[TB] FAIL sr_q got %b want 1001", q);
      else pass_cnt++;
      check_cnt++;
      if (sr_err !== 1'b1) $display("[TB] FAIL sr_err_set got %b want 1", sr_err);
      else pass_cnt++;
      drive(1'b1, 2'd3, 4'b0000, 4'b0000, 1'b1);
      tick();
      check_cnt++;
      if (sr_err !== 1'b0) $display("[TB] FAIL sr_err_clr got %b want 0", sr_err);
      else pass_cnt++;
      drive(1'b1, 2'd3, 4'b0100, 4'b0100, 1'b1);
      tick();
      check_cnt++;
      if (sr_err !== 1'b1) $display("[TB] FAIL sr_set_wins got %b want 1", sr_err);
      else pass_cnt++;
      check_cnt++;
      if (q !== model_q) $display("[TB] FAIL sr_clr_q got %b want %b", q, model_q);
      else pass_cnt++;
   endtask

   task automatic test_d();
      drive(1'b1, 2'd1, 4'b1010, 4'b1111, 1'b0);
      tick();
      check_cnt++;
      if (q !== 4'b1010) $display("[TB] FAIL d_q got %b want 1010", q);
      else pass_cnt++;
      check_cnt++;
      if (qbar !== 4'b0101) $display("[TB] FAIL d_qbar got %b want 0101", qbar);
      else pass_cnt++;
      check_cnt++;
      if (sr_err !== model_err) $display("[TB] FAIL d_sr_err got %b want %b", sr_err, model_err);
      else pass_cnt++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom),
               4'($urandom), ($urandom_range(0, 5) == 0));
         tick();
         check_cnt++;
         if (q !== model_q) $display("[TB] FAIL rand_q%0d got %b want %b", n, q, model_q);
         else pass_cnt++;
         check_cnt++;
         if (qbar !== ~model_q) $display("[TB] FAIL rand_qbar%0d got %b want %b", n, qbar, ~model_q);
         else pass_cnt++;
         check_cnt++;
         if (sr_err !== model_err) $display("[TB] FAIL rand_err%0d got %b want %b", n, sr_err, model_err);
         else pass_cnt++;
`ifdef JKFF_BANK_TOGGLE_CNT_EN
         check_cnt++;
         if (toggle_cnt !== 16'(model_cnt))
            $display("[TB] FAIL rand_cnt%0d got %0d want %0d", n, toggle_cnt, model_cnt);
         else pass_cnt++;
`endif
         if ($urandom_range(0, 39) == 0) begin
            #2;
            reset = 1'b1;
            #1;
            model_reset();
            check_cnt++;
            if (q !== RV || sr_err !== 1'b0)
               $display("[TB] FAIL rand_reset%0d got q=%b err=%b want q=%b err=0", n, q, sr_err, RV);
            else pass_cnt++;
            #1;
            reset = 1'b0;
         end
      end
   endtask

`ifdef JKFF_BANK_TOGGLE_CNT_EN
   task automatic test_toggle_cnt();
      drive(1'b0, 2'd2, 4'b0000, 4'b0000, 1'b1);
      tick();
      drive(1'b1, 2'd2, 4'b1111, 4'b0000, 1'b0);
      for (int n = 0; n < 70000; n++) tick();
      check_cnt++;
      if (toggle_cnt !== 16'hFFFF) $display("[TB] FAIL cnt_sat got %h want ffff", toggle_cnt);
      else pass_cnt++;
      drive(1'b1, 2'd2, 4'b1111, 4'b0000, 1'b1);
      tick();
      check_cnt++;
      if (toggle_cnt !== 16'h0000) $display("[TB] FAIL cnt_clr got %h want 0000", toggle_cnt);
      else pass_cnt++;
   endtask
`endif

   // Run the scenarios in order, then print the summary.
   initial begin
      test_reset();
      test_async_reset();
      test_jk();
      test_t_mode();
      test_sr();
      test_d();
      test_random();
`ifdef JKFF_BANK_TOGGLE_CNT_EN
      test_toggle_cnt();
`endif
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
